ex_mem_stage: RTL and testbench

//  EX/MEM pipeline register plus data-memory request sequencer. Captures the execute-stage result
//  (ALU output, store data, write-select, control bits) and drives the data-memory request for

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/dmem_req_fsm.sv | 58 +++++
 rtl/ex_mem_stage.sv | 98 +++++++++
 tb/tb_ex_mem_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths and the EX/MEM sequencer state.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} ex_mem_state_t;

   typedef struct packed {
      logic     dre;
      logic     dwe;
      logic     halt;
      logic     memtoreg;
      logic     wen;
      logic     jal;
      word_t    aluout;
      word_t    storedat;
      word_t    pc4;
      regbits_t wsel;
   } ex_mem_t;
endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer: issues one request per captured memory op, holds the
// pipeline until dhit, then reports the stage final for exactly one DONE cycle.
module dmem_req_fsm
   import cpu_types_pkg::*;
#(
   parameter int STALLCNT_W = 16
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  capture,
   input  logic                  capmem,
   input  logic                  dre,
   input  logic                  dwe,
   input  logic                  dhit,
   output logic                  dmemREN,
   output logic                  dmemWEN,
   output logic                  memstall,
   output logic                  memvalid,
   output logic [STALLCNT_W-1:0] memstallcnt
);
   ex_mem_state_t state, next;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next;
   end

   always_comb begin
      next     = state;
      dmemREN  = 1'b0;
      dmemWEN  = 1'b0;
      memstall = 1'b0;
      memvalid = 1'b0;
      case (state)
         IDLE: begin
            memvalid = 1'b1;
            if (capture && capmem) next = ACCESS;
         end
         ACCESS: begin
            // a store takes precedence when both enables are set
            memstall = 1'b1;
            dmemWEN  = dwe;
            dmemREN  = dre & ~dwe;
            if (dhit) next = DONE;
         end
         DONE: begin
            memvalid = 1'b1;
            next     = (capture && capmem) ? ACCESS : IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                           memstallcnt <= '0;
      else if (memstall && ~&memstallcnt)  memstallcnt <= memstallcnt + 1'b1;
   end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory request sequencing and sticky HALT.
module ex_mem_stage
   import cpu_types_pkg::*;
#(
   parameter int STALLCNT_W = 16
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  exW,
   input  logic                  exRST,
   input  logic                  excuDRE,
   input  logic                  excuDWE,
   input  logic                  excuHALT,
   input  logic                  exMemToReg,
   input  logic                  exWEN,
   input  logic                  exJALflag,
   input  word_t                 exaluout,
   input  word_t                 exstoredat,
   input  regbits_t              exwsel,
   input  word_t                 expc4,
   input  logic                  dhit,
   input  word_t                 dmemload,
   output logic                  dmemREN,
   output logic                  dmemWEN,
   output word_t                 dmemaddr,
   output word_t                 dmemstore,
   output logic                  memstall,
   output logic                  memvalid,
   output logic                  memMemToReg,
   output logic                  memWEN,
   output logic                  memJALflag,
   output logic                  memHALT,
   output word_t                 memaluout,
   output word_t                 memstoredat,
   output word_t                 mempc4,
   output word_t                 memloaddat,
   output regbits_t              memwsel,
   output logic [STALLCNT_W-1:0] memstallcnt
);
   ex_mem_t r, din;
   logic    capture, capmem;

   // HALT freezes the stage for good; a stalled stage never re-captures
   assign capture = (exW | exRST) & ~memstall & ~r.halt;
   assign capmem  = ~exRST & (excuDRE | excuDWE);

   always_comb begin
      din = '0;
      if (!exRST) begin
         din.dre      = excuDRE;
         din.dwe      = excuDWE;
         din.halt     = excuHALT;
         din.memtoreg = exMemToReg;
         din.wen      = exWEN;
         din.jal      = exJALflag;
         din.aluout   = exaluout;
         din.storedat = exstoredat;
         din.pc4      = expc4;
         din.wsel     = exwsel;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)        r <= '0;
      else if (capture) r <= din;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                memloaddat <= '0;
      else if (dmemREN && dhit) memloaddat <= dmemload;
   end

   dmem_req_fsm #(.STALLCNT_W(STALLCNT_W)) u_fsm (
      .CLK         (CLK),
      .nRST        (nRST),
      .capture     (capture),
      .capmem      (capmem),
      .dre         (r.dre),
      .dwe         (r.dwe),
      .dhit        (dhit),
      .dmemREN     (dmemREN),
      .dmemWEN     (dmemWEN),
      .memstall    (memstall),
      .memvalid    (memvalid),
      .memstallcnt (memstallcnt)
   );

   assign dmemaddr    = r.aluout;
   assign dmemstore   = r.storedat;
   assign memMemToReg = r.memtoreg;
   assign memWEN      = r.wen;
   assign memJALflag  = r.jal;
   assign memHALT     = r.halt;
   assign memaluout   = r.aluout;
   assign memstoredat = r.storedat;
   assign mempc4      = r.pc4;
   assign memwsel     = r.wsel;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized check of ex_mem_stage against a transaction-level model.
module tb_ex_mem_stage;
   logic        CLK = 1'b0, nRST = 1'b0;
   logic        exW = 0, exRST = 0, excuDRE = 0, excuDWE = 0, excuHALT = 0;
   logic        exMemToReg = 0, exWEN = 0, exJALflag = 0, dhit = 0;
   logic [31:0] exaluout = 0, exstoredat = 0, expc4 = 0, dmemload = 0;
   logic [4:0]  exwsel = 0;

   logic        dmemREN, dmemWEN, memstall, memvalid, memMemToReg, memWEN, memJALflag, memHALT;
   logic [31:0] dmemaddr, dmemstore, memaluout, memstoredat, mempc4, memloaddat;
   logic [4:0]  memwsel;
   logic [15:0] memstallcnt;

   logic        s_ren, s_wen, s_stall, s_valid, s_m2r, s_rwen, s_jal, s_halt;
   logic [31:0] s_addr, s_store, s_alu, s_st, s_pc4, s_ld;
   logic [4:0]  s_wsel;
   logic [1:0]  s_cnt;

   always #5 CLK = ~CLK;

   ex_mem_stage #(.STALLCNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST), .exW(exW), .exRST(exRST), .excuDRE(excuDRE), .excuDWE(excuDWE),
      .excuHALT(excuHALT), .exMemToReg(exMemToReg), .exWEN(exWEN), .exJALflag(exJALflag),
      .exaluout(exaluout), .exstoredat(exstoredat), .exwsel(exwsel), .expc4(expc4),
      .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .memstall(memstall), .memvalid(memvalid),
      .memMemToReg(memMemToReg), .memWEN(memWEN), .memJALflag(memJALflag), .memHALT(memHALT),
      .memaluout(memaluout), .memstoredat(memstoredat), .mempc4(mempc4),
      .memloaddat(memloaddat), .memwsel(memwsel), .memstallcnt(memstallcnt)
   );

   ex_mem_stage #(.STALLCNT_W(2)) u_sat (
      .CLK(CLK), .nRST(nRST), .exW(exW), .exRST(exRST), .excuDRE(excuDRE), .excuDWE(excuDWE),
      .excuHALT(excuHALT), .exMemToReg(exMemToReg), .exWEN(exWEN), .exJALflag(exJALflag),
      .exaluout(exaluout), .exstoredat(exstoredat), .exwsel(exwsel), .expc4(expc4),
      .dhit(dhit), .dmemload(dmemload), .dmemREN(s_ren), .dmemWEN(s_wen),
      .dmemaddr(s_addr), .dmemstore(s_store), .memstall(s_stall), .memvalid(s_valid),
      .memMemToReg(s_m2r), .memWEN(s_rwen), .memJALflag(s_jal), .memHALT(s_halt),
      .memaluout(s_alu), .memstoredat(s_st), .mempc4(s_pc4),
      .memloaddat(s_ld), .memwsel(s_wsel), .memstallcnt(s_cnt)
   );

   int errors = 0, checks = 0;

   // reference model: the contents the stage should hold, plus total stalled cycles
   logic        e_m2r, e_wen, e_jal, e_halt;
   logic [31:0] e_alu, e_st, e_pc4, e_ld;
   logic [4:0]  e_wsel;
   int          stall_total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      {e_m2r, e_wen, e_jal, e_halt} = '0;
      {e_alu, e_st, e_pc4, e_ld} = '0;
      e_wsel = '0;
      stall_total = 0;
   endtask

   task automatic model_capture(input logic bubble);
      if (bubble) begin
         {e_m2r, e_wen, e_jal, e_halt} = '0;
         {e_alu, e_st, e_pc4} = '0;
         e_wsel = '0;
      end else begin
         e_m2r = exMemToReg; e_wen = exWEN; e_jal = exJALflag; e_halt = excuHALT;
         e_alu = exaluout; e_st = exstoredat; e_pc4 = expc4; e_wsel = exwsel;
      end
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".m2r"},   memMemToReg, e_m2r);
      chk({tag, ".wen"},   memWEN, e_wen);
      chk({tag, ".jal"},   memJALflag, e_jal);
      chk({tag, ".halt"},  memHALT, e_halt);
      chk({tag, ".alu"},   memaluout, e_alu);
      chk({tag, ".st"},    memstoredat, e_st);
      chk({tag, ".pc4"},   mempc4, e_pc4);
      chk({tag, ".wsel"},  memwsel, e_wsel);
      chk({tag, ".ld"},    memloaddat, e_ld);
      chk({tag, ".addr"},  dmemaddr, e_alu);
      chk({tag, ".dst"},   dmemstore, e_st);
      chk({tag, ".cnt"},   memstallcnt, (stall_total > 65535) ? 65535 : stall_total);
      chk({tag, ".satcnt"}, s_cnt, (stall_total > 3) ? 3 : stall_total);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, ".ren"},   dmemREN, 1'b0);
      chk({tag, ".dwen"},  dmemWEN, 1'b0);
      chk({tag, ".stall"}, memstall, 1'b0);
      chk({tag, ".valid"}, memvalid, 1'b1);
   endtask

   task automatic rand_ex();
      exaluout = $urandom; exstoredat = $urandom; expc4 = $urandom; exwsel = 5'($urandom);
      exMemToReg = 1'($urandom); exWEN = 1'($urandom); exJALflag = 1'($urandom);
   endtask

   // one instruction: capture, then every ACCESS cycle, then the DONE cycle
   task automatic issue(input string tag, input logic dre, input logic dwe, input logic halt,
                        input int waits, input logic noisy);
      logic [31:0] ld;
      excuDRE = dre; excuDWE = dwe; excuHALT = halt; exW = 1; exRST = 0;
      tick();
      model_capture(1'b0);
      exW = 0; excuHALT = 0;
      if (!(dre | dwe)) begin
         check_quiet(tag);
         check_regs(tag);
         return;
      end
      ld = '0;
      for (int k = 0; k <= waits; k++) begin
         chk({tag, ".acc_ren"},   dmemREN, dre & ~dwe);
         chk({tag, ".acc_wen"},   dmemWEN, dwe);
         chk({tag, ".acc_stall"}, memstall, 1'b1);
         chk({tag, ".acc_valid"}, memvalid, 1'b0);
         chk({tag, ".acc_addr"},  dmemaddr, e_alu);
         chk({tag, ".acc_st"},    dmemstore, e_st);
         if (noisy) begin
            exW = 1'($urandom); exRST = 1'($urandom); rand_ex();
         end
         dhit = (k == waits);
         dmemload = $urandom;
         ld = dmemload;
         tick();
         stall_total++;
      end
      dhit = 0; exW = 0; exRST = 0;
      if (dre & ~dwe) e_ld = ld;
      check_quiet({tag, ".done"});
      check_regs({tag, ".done"});
   endtask

   initial begin
      model_reset();
      #12;
      check_regs("reset");
      chk("reset.ren", dmemREN, 1'b0);
      chk("reset.stall", memstall, 1'b0);
      nRST = 1;
      tick();

      // asynchronous reset in the middle of a held load
      exaluout = 32'h40; excuDRE = 1; exW = 1;
      tick();
      exW = 0; excuDRE = 0;
      chk("rstmid.ren_before", dmemREN, 1'b1);
      tick();
      #2 nRST = 0;
      #1;
      model_reset();
      chk("rstmid.ren", dmemREN, 1'b0);
      chk("rstmid.stall", memstall, 1'b0);
      check_regs("rstmid");
      #2 nRST = 1;
      tick();
      check_quiet("rstmid.idle");

      // plain ALU op
      rand_ex(); exaluout = 32'h10; exwsel = 5'd5; exWEN = 1;
      issue("alu", 0, 0, 0, 0, 0);

      // load with three wait cycles: four stalled cycles
      rand_ex(); exaluout = 32'h100;
      excuDRE = 1; excuDWE = 0; exW = 1;
      tick();
      model_capture(1'b0);
      exW = 0; excuDRE = 0;
      for (int k = 0; k < 4; k++) begin
         chk("ld3.ren", dmemREN, 1'b1);
         chk("ld3.addr", dmemaddr, 32'h100);
         chk("ld3.stall", memstall, 1'b1);
         dhit = (k == 3);
         dmemload = 32'hDEADBEEF;
         tick();
         stall_total++;
      end
      dhit = 0;
      e_ld = 32'hDEADBEEF;
      chk("ld3.ld", memloaddat, 32'hDEADBEEF);
      chk("ld3.cnt", memstallcnt, 16'd4);
      chk("ld3.satcnt", s_cnt, 2'd3);
      check_quiet("ld3.done");
      tick();
      chk("ld3.valid_after", memvalid, 1'b1);
      check_regs("ld3.after");

      // store with both enables and immediate hit
      rand_ex();
      issue("stboth", 1, 1, 0, 0, 0);

      // flush ignored while in ACCESS, then a bubble from IDLE
      rand_ex();
      issue("flushacc", 1, 0, 0, 2, 1);
      tick();
      exRST = 1; exW = 1'($urandom); rand_ex();
      tick();
      model_capture(1'b1);
      exRST = 0; exW = 0;
      check_quiet("flushidle");
      check_regs("flushidle");

      // randomized instruction mix, back-to-back from DONE
      for (int i = 0; i < 40; i++) begin
         logic [1:0] kind;
         kind = 2'($urandom);
         rand_ex();
         issue($sformatf("rnd%0d", i), kind[0], kind[1], 0, $urandom_range(0, 3), 1'($urandom));
         if ($urandom_range(0, 3) == 0) tick();
      end

      // HALT is sticky: later loads are neither captured nor issued
      rand_ex();
      issue("halt", 0, 0, 1, 0, 0);
      rand_ex(); excuDRE = 1; exW = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("halt.ren", dmemREN, 1'b0);
         check_quiet("halt.hold");
         check_regs("halt.hold");
      end
      exW = 0; excuDRE = 0;
      #2 nRST = 0;
      #1;
      model_reset();
      check_regs("halt.cleared");
      #2 nRST = 1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
